// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits, one cell per baud_tick.
// tx is registered and moves one clk after each sampled tick; s_ready is high only while idle, so senders are held off.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int            CW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);
  localparam logic          PAR_EN    = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;
  logic [CW-1:0]          r_bit_cnt;
  logic [1:0]             r_stop_cnt;
  logic                   r_tx;
  logic                   r_tx_done;

  state_t                 w_state_nxt;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic                   w_parity_nxt;
  logic [CW-1:0]          w_bit_cnt_nxt;
  logic [1:0]             w_stop_cnt_nxt;
  logic                   w_tx_nxt;
  logic                   w_tx_done_nxt;
  logic                   w_accept;

  assign s_ready  = (r_state == S_IDLE);
  assign busy     = ~s_ready;
  assign tx       = r_tx;
  assign tx_done  = r_tx_done;
  assign w_accept = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_done  <= w_tx_done_nxt;
    end
  end

  // SYNC exists so a tick coinciding with acceptance never shortens the start cell.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_parity_nxt   = r_parity;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_tx_nxt       = r_tx;
    w_tx_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_shift_nxt  = s_data;
          w_parity_nxt = (^s_data) ^ PAR_ODD;
          w_state_nxt  = S_SYNC;
        end
      end
      S_SYNC: begin
        if (baud_tick) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          w_state_nxt   = S_DATA;
          w_tx_nxt      = r_shift[0];
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (r_bit_cnt < LAST_BIT) begin
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end else if (PAR_EN) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_parity;
          end else begin
            w_state_nxt    = S_STOP;
            w_tx_nxt       = 1'b1;
            w_stop_cnt_nxt = '0;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          w_state_nxt    = S_STOP;
          w_tx_nxt       = 1'b1;
          w_stop_cnt_nxt = '0;
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (baud_tick) begin
          if (r_stop_cnt < LAST_STOP) begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end else begin
            w_state_nxt   = S_IDLE;
            w_tx_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx over six frame formats sharing one 278-clk baud tick.
// Drivers push expected frames at acceptance; per-instance monitors check every clk of every bit cell.
module tb_uart_tx;

  localparam int NC   = 6;
  localparam int TPER = 278;

  function automatic int cfg_db(input int i);
    case (i)
      4:       return 5;
      5:       return 9;
      default: return 8;
    endcase
  endfunction
  function automatic int cfg_pe(input int i);
    return (i == 1 || i == 2 || i == 4 || i == 5) ? 1 : 0;
  endfunction
  function automatic int cfg_po(input int i);
    return (i == 2 || i == 4) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 3 || i == 4) ? 2 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [8:0] s_dat [NC];
  logic       s_vld [NC];
  logic       s_rdy [NC];
  logic       tx_a  [NC];
  logic       busy_a[NC];
  logic       txd_a [NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    uart_tx #(
      .DATA_BITS (cfg_db(g)),
      .PARITY_EN (cfg_pe(g)),
      .PARITY_ODD(cfg_po(g)),
      .STOP_BITS (cfg_sb(g))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_tick(baud_tick),
      .s_data   (s_dat[g][cfg_db(g)-1:0]),
      .s_valid  (s_vld[g]),
      .s_ready  (s_rdy[g]),
      .tx       (tx_a[g]),
      .busy     (busy_a[g]),
      .tx_done  (txd_a[g])
    );
  end

  typedef struct {
    logic [8:0] d;
    int         acc;
  } item_t;

  item_t sbq [NC][$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    ecnt = 0;
  int    tcnt = 0;
  int    drv_done = 0;
  int    idle_bad [NC];

  always #5 clk = ~clk;

  // Baud generator model: ecnt counts rising edges; baud_tick is set for the edge ecnt+1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ecnt++;
      tcnt = (tcnt == TPER - 1) ? 0 : tcnt + 1;
      baud_tick = (tcnt == TPER - 1);
    end
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d: got %0h, expected %0h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input int k);
    return 1 + cfg_db(k) + cfg_pe(k) + cfg_sb(k);
  endfunction

  // Expected line level of cell c of a frame carrying d.
  function automatic logic exp_bit(input int k, input logic [8:0] d, input int c);
    int db;
    db = cfg_db(k);
    if (c == 0) return 1'b0;
    if (c <= db) return d[c-1];
    if (cfg_pe(k) != 0 && c == db + 1) return (^d) ^ (cfg_po(k) != 0);
    return 1'b1;
  endfunction

  task automatic push(input int k, input logic [8:0] d, input int acc);
    item_t it;
    int    m;
    m = (1 << cfg_db(k)) - 1;
    it.d = d & m[8:0];
    it.acc = acc;
    sbq[k].push_back(it);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input int k, input logic [8:0] d, input bit keep_valid);
    int w;
    w = 0;
    s_dat[k] = d;
    s_vld[k] = 1'b1;
    while (!s_rdy[k]) begin
      @(negedge clk);
      w++;
      if (w > 20000) begin
        chk("send_timeout", k, 0, 1);
        s_vld[k] = 1'b0;
        return;
      end
    end
    push(k, d, ecnt + 1);
    @(negedge clk);
    s_dat[k] = 9'($urandom);
    if (!keep_valid) s_vld[k] = 1'b0;
  endtask

  task automatic gap(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      s_dat[k] = 9'($urandom);
    end
  endtask

  task automatic driver(input int k);
    int w;
    logic [8:0] d0;
    case (k)
      0:       d0 = 9'h0A5;
      1, 2:    d0 = 9'h007;
      3:       d0 = 9'h0FF;
      default: d0 = 9'($urandom);
    endcase
    send(k, d0, 1'b0);
    gap(k, $urandom_range(0, 50));
    send(k, 9'h055, 1'b1);
    send(k, 9'h0AA, 1'b0);
    w = 0;
    while (!(s_rdy[k] && baud_tick) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("tick_align_wait", k, int'(s_rdy[k] && baud_tick), 1);
    send(k, 9'($urandom), 1'b0);
    repeat (3) begin
      gap(k, $urandom_range(0, 400));
      send(k, 9'($urandom), 1'b0);
    end
    drv_done++;
  endtask

  // Checks one frame from the current negedge; aborts and flushes on reset.
  task automatic run_frame(input int k, input item_t it);
    int T, len, w;
    bit ok;
    logic e;
    len = frame_len(k);
    ok = 1'b1;
    w = 0;
    forever begin
      if (!rst_n) begin
        sbq[k].delete();
        return;
      end
      if (tx_a[k] !== 1'b1 || txd_a[k] !== 1'b0) ok = 1'b0;
      if (ecnt >= it.acc && busy_a[k] !== 1'b1) ok = 1'b0;
      if (ecnt >= it.acc && baud_tick) break;
      if (++w > 600) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk("sync_mark", k, int'(ok), 1);
    T = ecnt + 1;
    for (int c = 0; c < len; c++) begin
      e = exp_bit(k, it.d, c);
      ok = 1'b1;
      for (int j = 0; j < TPER; j++) begin
        @(negedge clk);
        if (!rst_n) begin
          sbq[k].delete();
          return;
        end
        if (tx_a[k] !== e || busy_a[k] !== 1'b1 || txd_a[k] !== 1'b0) ok = 1'b0;
      end
      chk($sformatf("cell%0d_d%0h", c, it.d), k, int'(ok), 1);
    end
    @(negedge clk);
    chk("done_edge", k, ecnt, T + len * TPER);
    chk("tx_done_pulse", k, {28'd0, txd_a[k], busy_a[k], s_rdy[k], tx_a[k]}, 4'b1011);
    void'(sbq[k].pop_front());
  endtask

  task automatic monitor(input int k);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq[k].delete();
      end else if (sbq[k].size() == 0) begin
        if (tx_a[k] !== 1'b1 || txd_a[k] !== 1'b0) idle_bad[k]++;
      end else begin
        run_frame(k, sbq[k][0]);
      end
    end
  endtask

  // All instances are idle when called: every one accepts on the next edge.
  task automatic send_all(input logic [8:0] d);
    for (int k = 0; k < NC; k++) begin
      chk("ready_before_send_all", k, int'(s_rdy[k]), 1);
      s_dat[k] = d;
      s_vld[k] = 1'b1;
      push(k, d, ecnt + 1);
    end
    @(negedge clk);
    for (int k = 0; k < NC; k++) s_vld[k] = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w;
    bit empty;
    w = 0;
    empty = 1'b0;
    while (!empty && w < 8000) begin
      @(negedge clk);
      w++;
      empty = 1'b1;
      for (int k = 0; k < NC; k++) if (sbq[k].size() != 0) empty = 1'b0;
    end
    chk(nm, 0, int'(empty), 1);
  endtask

  initial begin
    int w, T, A;
    bit ok [NC];
    for (int k = 0; k < NC; k++) begin
      s_vld[k] = 1'b0;
      s_dat[k] = '0;
      idle_bad[k] = 0;
    end
    for (int i = 0; i < NC; i++) begin
      fork
        automatic int k = i;
        monitor(k);
      join_none
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NC; k++)
      chk("reset_state", k, {28'd0, txd_a[k], busy_a[k], s_rdy[k], tx_a[k]}, 4'b0011);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NC; i++) begin
      fork
        automatic int k = i;
        driver(k);
      join_none
    end
    w = 0;
    while (drv_done < NC && w < 60000) begin
      @(negedge clk);
      w++;
    end
    chk("drivers_done", 0, drv_done, NC);
    drain("drain_random");
    repeat (5) @(negedge clk);

    // Abort a frame mid-data: zero data keeps tx low until the async reset.
    send_all(9'h000);
    A = ecnt;
    w = 0;
    while (!(baud_tick && ecnt >= A) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    T = ecnt + 1;
    while (ecnt < T + 4 * TPER + 100) @(negedge clk);
    for (int k = 0; k < NC; k++) chk("tx_low_before_reset", k, int'(tx_a[k]), 0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NC; k++)
      chk("async_reset", k, {28'd0, txd_a[k], busy_a[k], s_rdy[k], tx_a[k]}, 4'b0011);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < NC; k++) ok[k] = 1'b1;
    repeat (2 * TPER) begin
      @(negedge clk);
      for (int k = 0; k < NC; k++)
        if (tx_a[k] !== 1'b1 || txd_a[k] !== 1'b0 || s_rdy[k] !== 1'b1 || busy_a[k] !== 1'b0) ok[k] = 1'b0;
    end
    for (int k = 0; k < NC; k++) chk("post_reset_idle", k, int'(ok[k]), 1);
    send_all(9'h03C);
    drain("drain_after_reset");
    repeat (TPER) @(negedge clk);

    for (int k = 0; k < NC; k++) begin
      chk("queue_empty", k, sbq[k].size(), 0);
      chk("idle_line_clean", k, idle_bad[k], 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
